// File: rtl/nrs_ls_averager.sv
// nrs_ls_averager: coherent N-product averager for LS channel estimates with rounding, saturation and valid/ready handshakes
module nrs_ls_averager #(
    parameter int WIDTH_R_I  = 16,
    parameter int LOG2_N     = 3,
    parameter int FRAC_SHIFT = 15,
    parameter int OUT_W      = 16
)(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*WIDTH_R_I-1:0] prod_in,
    output logic                   est_valid,
    input  logic                   est_ready,
    output logic [2*OUT_W-1:0]     est_out,
    output logic                   sat_flag,
    output logic                   busy
);
    localparam int PW = 2*WIDTH_R_I;
    localparam int AW = PW + LOG2_N + 1;
    localparam int CW = LOG2_N + 1;
    localparam int S  = LOG2_N + FRAC_SHIFT;
    localparam int RW = AW + 1;
    localparam logic [CW-1:0]        N_CNT = CW'(2**LOG2_N);
    localparam logic signed [RW-1:0] ONE   = 1;
    localparam logic signed [RW-1:0] HALF  = ONE <<< (S-1);
    localparam logic signed [RW-1:0] MAXV  = (ONE <<< (OUT_W-1)) - ONE;
    localparam logic signed [RW-1:0] MINV  = -(ONE <<< (OUT_W-1));

    typedef enum logic [1:0] {IDLE, ACC, SCALE, HOLD} state_t;

    state_t                 state, state_nxt;
    logic signed [AW-1:0]   acc_re, acc_im;
    logic [CW-1:0]          count, cnt_nxt;
    logic signed [PW-1:0]   p_re, p_im;
    logic signed [RW-1:0]   r_re, r_im;
    logic [OUT_W-1:0]       q_re, q_im;
    logic                   accept, last, sat_re, sat_im;

    assign p_re     = prod_in[2*PW-1:PW];
    assign p_im     = prod_in[PW-1:0];
    assign in_ready = state == IDLE || state == ACC;
    assign busy     = state != IDLE;
    // a flushed cycle never consumes the product presented with it
    assign accept   = in_valid & in_ready & ~flush;
    assign cnt_nxt  = state == IDLE ? CW'(1) : count + CW'(1);
    assign last     = cnt_nxt == N_CNT;

    // round half up then arithmetic shift; one extra bit keeps the bias add from overflowing
    assign r_re   = ($signed({acc_re[AW-1], acc_re}) + HALF) >>> S;
    assign r_im   = ($signed({acc_im[AW-1], acc_im}) + HALF) >>> S;
    assign sat_re = r_re > MAXV || r_re < MINV;
    assign sat_im = r_im > MAXV || r_im < MINV;
    assign q_re   = r_re > MAXV ? MAXV[OUT_W-1:0] : r_re < MINV ? MINV[OUT_W-1:0] : r_re[OUT_W-1:0];
    assign q_im   = r_im > MAXV ? MAXV[OUT_W-1:0] : r_im < MINV ? MINV[OUT_W-1:0] : r_im[OUT_W-1:0];

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // next state: flush aborts everything except a pending estimate in HOLD
    always_comb begin
        state_nxt = state;
        if (flush && state != HOLD) state_nxt = IDLE;
        else begin
            case (state)
                IDLE:    state_nxt = accept ? (last ? SCALE : ACC) : IDLE;
                ACC:     state_nxt = accept && last ? SCALE : ACC;
                SCALE:   state_nxt = HOLD;
                default: state_nxt = est_ready ? IDLE : HOLD;
            endcase
        end
    end

    // accumulators, product counter and registered estimate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_re    <= '0;
            acc_im    <= '0;
            count     <= '0;
            est_out   <= '0;
            est_valid <= 1'b0;
            sat_flag  <= 1'b0;
        end else begin
            if (flush) begin
                acc_re <= '0;
                acc_im <= '0;
                count  <= '0;
            end else if (accept) begin
                acc_re <= (state == IDLE ? '0 : acc_re) + AW'(p_re);
                acc_im <= (state == IDLE ? '0 : acc_im) + AW'(p_im);
                count  <= cnt_nxt;
            end
            if (state == SCALE && !flush) begin
                est_out   <= {q_re, q_im};
                est_valid <= 1'b1;
                sat_flag  <= sat_re | sat_im;
            end
            if (state == HOLD && est_ready) begin
                est_valid <= 1'b0;
                acc_re    <= '0;
                acc_im    <= '0;
                count     <= '0;
            end
        end
    end
endmodule

// File: tb/tb_nrs_ls_averager.sv
// tb_nrs_ls_averager: directed scoreboard bench for nrs_ls_averager
module tb_nrs_ls_averager;
    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, est_valid, est_ready, sat_flag, busy;
    logic [63:0] prod_in;
    logic [31:0] est_out;

    typedef struct {logic [15:0] re; logic [15:0] im; logic sat;} exp_t;
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;

    nrs_ls_averager dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .prod_in(prod_in), .est_valid(est_valid), .est_ready(est_ready), .est_out(est_out),
        .sat_flag(sat_flag), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: compare each handshaken estimate with the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && est_valid && est_ready) begin
                if (sb.size() == 0) chk("unexpected_est", 64'(est_out), 64'hFFFF_FFFF);
                else begin
                    e = sb.pop_front();
                    chk("est_re", 64'(est_out[31:16]), 64'(e.re));
                    chk("est_im", 64'(est_out[15:0]), 64'(e.im));
                    chk("sat_flag", 64'(sat_flag), 64'(e.sat));
                end
            end
        end
    end

    task automatic put(input logic [31:0] re, input logic [31:0] im, input bit bubble);
        int t = 0;
        in_valid = 1'b1;
        prod_in  = {re, im};
        while (!in_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 50) chk("accept_timeout", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (bubble) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic group(input logic [31:0] re, input logic [31:0] im, input int n, input bit bubble);
        for (int i = 0; i < n; i++) put(re, im, bubble);
    endtask

    task automatic wait_valid();
        int t = 0;
        while (!est_valid && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        chk("est_valid_seen", 64'(est_valid), 64'd1);
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk("drain", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; prod_in = '0; est_ready = 1'b1;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_est_valid", 64'(est_valid), 64'd0);
        chk("rst_est_out", 64'(est_out), 64'd0);
        chk("rst_sat", 64'(sat_flag), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // nominal average and latency (counted from the accepting edge)
        sb.push_back('{16'h4000, 16'hC000, 1'b0});
        group(32'h2000_0000, 32'hE000_0000, 8, 1'b0);
        n = 1;
        while (!est_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency_edges", 64'(n), 64'd2);
        drain();

        // rounding: half rounds up on real, exact zero on imag
        sb.push_back('{16'h0001, 16'h0000, 1'b0});
        put(32'h0002_0000, 32'hFFFE_0000, 1'b0);
        group(32'h0, 32'h0, 7, 1'b0);
        drain();

        // saturation in both directions
        sb.push_back('{16'h7FFF, 16'h8000, 1'b1});
        group(32'h4000_0000, 32'h8000_0000, 8, 1'b0);
        drain();

        // backpressure: estimate held, extra product not consumed
        est_ready = 1'b0;
        sb.push_back('{16'h2000, 16'h0000, 1'b0});
        group(32'h1000_0000, 32'h0, 8, 1'b0);
        wait_valid();
        in_valid = 1'b1;
        prod_in  = {32'h7FFF_FFFF, 32'h7FFF_FFFF};
        for (int i = 0; i < 5; i++) begin
            chk("bp_est_out", 64'(est_out), 64'h2000_0000);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_est_valid", 64'(est_valid), 64'd1);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        est_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", 64'(est_valid), 64'd0);
        chk("bp_release_ready", 64'(in_ready), 64'd1);
        chk("bp_release_busy", 64'(busy), 64'd0);
        drain();

        // flush mid-group: only post-flush data contributes
        group(32'h2000_0000, 32'h0, 3, 1'b0);
        flush    = 1'b1;
        in_valid = 1'b1;
        prod_in  = {32'h2000_0000, 32'h0};
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        sb.push_back('{16'h2000, 16'h0000, 1'b0});
        group(32'h1000_0000, 32'h0, 8, 1'b0);
        drain();

        // bubbles, then asynchronous reset while holding an estimate
        est_ready = 1'b0;
        group(32'h2000_0000, 32'hE000_0000, 8, 1'b1);
        wait_valid();
        chk("bubble_est_out", 64'(est_out), 64'h4000_C000);
        chk("bubble_sat", 64'(sat_flag), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_est_valid", 64'(est_valid), 64'd0);
        chk("arst_est_out", 64'(est_out), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        chk("arst_busy", 64'(busy), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        est_ready = 1'b1;

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
